// File: rtl/hcode_arb_pkg.sv
// Shared types and default sizes for the host-output round-robin arbiter.
package hcode_arb_pkg;

  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_N_CH   = 4;
  localparam int unsigned CHAN_W     = $clog2(DEF_N_CH);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/hcode_rr_pick.sv
// Rotating-priority encoder: first set request strictly after ptr, wrapping modulo N_REQ.
module hcode_rr_pick
  import hcode_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = DEF_N_CH,
  localparam int unsigned PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any
);

  logic [PTR_W-1:0] w_idx;

  // Scan farthest-first so the nearest requester after ptr is the last to win.
  always_comb begin
    grant = '0;
    w_idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      w_idx = ptr + PTR_W'(i);
      if (req[w_idx]) grant = w_idx;
    end
  end

  assign any = |req;

endmodule

// File: rtl/hcode_out_arbiter.sv
// Merges the subshell output FIFOs into the single host return FIFO,
// popping one channel at a time in bounded bursts with rotating priority.
module hcode_out_arbiter
  import hcode_arb_pkg::*;
#(
  parameter  int unsigned DATA_W    = DEF_DATA_W,
  parameter  int unsigned N_CH      = DEF_N_CH,
  parameter  int unsigned MAX_BURST = 16,
  localparam int unsigned CH_W      = $clog2(N_CH),
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                   ip_clk,
  input  logic                   ip_rst_n,
  input  logic [N_CH*DATA_W-1:0] ch_dout,
  input  logic [N_CH-1:0]        ch_empty_n,
  output logic [N_CH-1:0]        ch_read,
  output logic [DATA_W-1:0]      out_din,
  output logic [CH_W-1:0]        out_chan,
  input  logic                   out_full,
  output logic                   out_write
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_obuf_chan;
  logic [CH_W-1:0]   w_pick;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic [DATA_W-1:0] r_obuf;
  logic              r_obuf_valid;
  logic              w_any;
  logic              w_load_ok;
  logic              w_pop;
  logic              w_last;

  hcode_rr_pick #(.N_REQ(N_CH)) u_pick (
    .req   (ch_empty_n),
    .ptr   (r_rr_ptr),
    .grant (w_pick),
    .any   (w_any)
  );

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) r_state <= IDLE;
    else           r_state <= w_state_nxt;
  end

  assign w_last = (r_burst_cnt == CNT_W'(MAX_BURST - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nxt = BURST;
      BURST:   if (!ch_empty_n[r_grant] || (w_pop && w_last)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // A pop is allowed whenever the output buffer is free or drains this cycle.
  always_comb begin
    w_load_ok = ~r_obuf_valid | ~out_full;
    w_pop     = 1'b0;
    ch_read   = '0;
    if (r_state == BURST) begin
      w_pop            = ch_empty_n[r_grant] & w_load_ok;
      ch_read[r_grant] = w_pop;
    end
  end

  always_ff @(posedge ip_clk or negedge ip_rst_n) begin
    if (!ip_rst_n) begin
      r_grant      <= '0;
      r_rr_ptr     <= CH_W'(N_CH - 1);
      r_burst_cnt  <= '0;
      r_obuf       <= '0;
      r_obuf_chan  <= '0;
      r_obuf_valid <= 1'b0;
    end else begin
      if (r_state == IDLE && w_any) begin
        r_grant     <= w_pick;
        r_rr_ptr    <= w_pick;
        r_burst_cnt <= '0;
      end
      if (w_pop) begin
        r_obuf       <= ch_dout[r_grant*DATA_W +: DATA_W];
        r_obuf_chan  <= r_grant;
        r_obuf_valid <= 1'b1;
        r_burst_cnt  <= r_burst_cnt + CNT_W'(1);
      end else if (out_write) begin
        r_obuf_valid <= 1'b0;
      end
    end
  end

  assign out_din   = r_obuf;
  assign out_chan  = r_obuf_chan;
  assign out_write = r_obuf_valid & ~out_full;

endmodule

// File: tb/tb_hcode_out_arbiter.sv
// Self-checking bench for hcode_out_arbiter: FWFT channel queues, per-channel
// ordering scoreboard, cycle-exact tables and hand sequences for corner cases.
module tb_hcode_out_arbiter;

  localparam int unsigned DW = 128;
  localparam int unsigned NC = 4;
  localparam int unsigned MB = 16;

  logic               ip_clk;
  logic               ip_rst_n;
  logic [NC*DW-1:0]   ch_dout;
  logic [NC-1:0]      ch_empty_n;
  logic [NC-1:0]      ch_read;
  logic [DW-1:0]      out_din;
  logic [1:0]         out_chan;
  logic               out_full;
  logic               out_write;

  hcode_out_arbiter #(.DATA_W(DW), .N_CH(NC), .MAX_BURST(MB)) dut (
    .ip_clk     (ip_clk),
    .ip_rst_n   (ip_rst_n),
    .ch_dout    (ch_dout),
    .ch_empty_n (ch_empty_n),
    .ch_read    (ch_read),
    .out_din    (out_din),
    .out_chan   (out_chan),
    .out_full   (out_full),
    .out_write  (out_write)
  );

  initial begin
    ip_clk = 1'b0;
    forever #5 ip_clk = ~ip_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic          full;
    logic [NC-1:0] rd;
    logic          wr;
    logic [DW-1:0] din;
    logic [1:0]    chan;
  } vec_t;

  vec_t          tv [8];
  logic [DW-1:0] q  [NC][$];
  logic [DW-1:0] sb [NC][$];
  int            seqn [NC];
  logic          autofill [NC];
  int            n_checks;
  int            n_fail;
  int            n_wr;
  logic [NC-1:0] s_rd;
  logic          s_wr;
  logic [DW-1:0] s_din;
  logic [1:0]    s_chan;

  function automatic logic [DW-1:0] mk(input int ch, input int seq);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1 -: 8] = 8'(ch + 1);
    w[31:0]      = 32'(seq);
    return w;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NC; i++) begin
      if (autofill[i]) begin
        while (q[i].size() < 3) begin
          q[i].push_back(mk(i, seqn[i]));
          seqn[i]++;
        end
      end
      ch_empty_n[i]         = (q[i].size() != 0);
      ch_dout[i*DW +: DW]   = (q[i].size() != 0) ? q[i][0] : '0;
    end
  endtask

  // One clock cycle: sample mid-cycle, score writes, then apply sampled pops after the edge.
  task automatic step();
    logic [NC-1:0] rd;
    logic          wr;
    logic [DW-1:0] din;
    logic [1:0]    chn;
    #5;
    rd  = ch_read;
    wr  = out_write;
    din = out_din;
    chn = out_chan;
    s_rd = rd; s_wr = wr; s_din = din; s_chan = chn;
    check("rd_onehot0", DW'($onehot0(rd)), DW'(1));
    check("rd_when_empty", DW'(rd & ~ch_empty_n), '0);
    if (wr) begin
      n_wr++;
      if (sb[chn].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_write: chan=%0d got=0x%0h expected no write", chn, din);
      end else begin
        check("sb_data", din, sb[chn].pop_front());
      end
    end
    @(posedge ip_clk);
    #1;
    for (int i = 0; i < NC; i++) begin
      if (rd[i] && q[i].size() != 0) sb[i].push_back(q[i].pop_front());
    end
    drive();
  endtask

  task automatic clear_model();
    for (int i = 0; i < NC; i++) begin
      q[i].delete();
      sb[i].delete();
      seqn[i]     = 0;
      autofill[i] = 1'b0;
    end
    out_full = 1'b0;
    drive();
  endtask

  task automatic do_reset();
    ip_rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge ip_clk);
    #1;
    ip_rst_n = 1'b1;
    n_wr = 0;
  endtask

  task automatic drain_check(input string name);
    int pend;
    out_full = 1'b0;
    for (int i = 0; i < NC; i++) autofill[i] = 1'b0;
    pend = 0;
    for (int k = 0; k < 600; k++) begin
      pend = 0;
      for (int i = 0; i < NC; i++) pend += int'(q[i].size()) + int'(sb[i].size());
      if (pend == 0) break;
      step();
    end
    pend = 0;
    for (int i = 0; i < NC; i++) pend += int'(q[i].size()) + int'(sb[i].size());
    check(name, DW'(pend), '0);
  endtask

  initial begin
    int first1, first3;
    int k;
    logic [NC-1:0] exp_rd;
    logic [NC-1:0] prev_rd;
    logic [DW-1:0] stall_din;

    n_checks = 0; n_fail = 0; n_wr = 0;
    ip_rst_n = 1'b1;
    ch_empty_n = '0;
    ch_dout = '0;
    out_full = 1'b0;
    for (int i = 0; i < NC; i++) begin seqn[i] = 0; autofill[i] = 1'b0; end

    tv[0] = '{1'b0, 4'b0000, 1'b0, '0,        2'd0};
    tv[1] = '{1'b0, 4'b0100, 1'b0, '0,        2'd0};
    tv[2] = '{1'b0, 4'b0100, 1'b1, mk(2, 1),  2'd2};
    tv[3] = '{1'b0, 4'b0100, 1'b1, mk(2, 2),  2'd2};
    tv[4] = '{1'b0, 4'b0100, 1'b1, mk(2, 3),  2'd2};
    tv[5] = '{1'b0, 4'b0100, 1'b1, mk(2, 4),  2'd2};
    tv[6] = '{1'b0, 4'b0000, 1'b1, mk(2, 5),  2'd2};
    tv[7] = '{1'b0, 4'b0000, 1'b0, mk(2, 5),  2'd2};

    // Reset values, then quiet inputs.
    #1;
    ip_rst_n = 1'b0;
    #2;
    check("reset_ch_read", DW'(ch_read), '0);
    check("reset_out_write", DW'(out_write), '0);
    check("reset_out_din", out_din, '0);
    check("reset_out_chan", DW'(out_chan), '0);
    do_reset();
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_rd", DW'(s_rd), '0);
      check("idle_wr", DW'(s_wr), '0);
    end

    // Single channel, five words, cycle-exact table.
    for (int j = 1; j <= 5; j++) q[2].push_back(mk(2, j));
    drive();
    for (int c = 0; c < 8; c++) begin
      out_full = tv[c].full;
      step();
      check("tv_rd", DW'(s_rd), DW'(tv[c].rd));
      check("tv_wr", DW'(s_wr), DW'(tv[c].wr));
      check("tv_din", s_din, tv[c].din);
      check("tv_chan", DW'(s_chan), DW'(tv[c].chan));
    end
    q[2].push_back(mk(2, 6));
    drive();
    step();
    check("reidle_rd_bubble", DW'(s_rd), '0);
    step();
    check("reidle_rd_grant", DW'(s_rd), DW'(4'b0100));
    drain_check("single_drain");

    // All channels always ready: 16-word bursts in order 0,1,2,3,0 with one bubble.
    do_reset();
    for (int i = 0; i < NC; i++) autofill[i] = 1'b1;
    drive();
    prev_rd = '0;
    for (int c = 0; c < 86; c++) begin
      step();
      exp_rd = '0;
      if (c >= 1) begin
        k = (c - 1) % (MB + 1);
        if (k < int'(MB)) exp_rd[((c - 1) / (MB + 1)) % NC] = 1'b1;
      end
      check("rr_rd", DW'(s_rd), DW'(exp_rd));
      check("rr_wr", DW'(s_wr), DW'(prev_rd != 0));
      prev_rd = s_rd;
    end
    drain_check("rr_drain");

    // Upstream full for three cycles mid-burst.
    do_reset();
    autofill[0] = 1'b1;
    drive();
    stall_din = '0;
    for (int c = 0; c < 30; c++) begin
      out_full = (c >= 6 && c <= 8);
      step();
      if (c == 6) begin
        stall_din = s_din;
        check("stall_word", s_din, mk(0, 4));
      end
      if (c >= 6 && c <= 8) begin
        check("stall_rd", DW'(s_rd), '0);
        check("stall_wr", DW'(s_wr), '0);
        check("stall_din_hold", s_din, stall_din);
      end
      if (c == 9) begin
        check("resume_wr", DW'(s_wr), DW'(1));
        check("resume_din", s_din, mk(0, 4));
      end
    end
    drain_check("stall_drain");

    // ch1 runs dry after 3 words while ch3 waits.
    do_reset();
    for (int j = 0; j < 3; j++) q[1].push_back(mk(1, j));
    for (int j = 0; j < 4; j++) q[3].push_back(mk(3, j));
    drive();
    first1 = -1; first3 = -1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (s_rd == 4'b0010 && first1 < 0) first1 = c;
      if (s_rd == 4'b1000 && first3 < 0) first3 = c;
    end
    check("drain_first_ch1", DW'(first1), DW'(1));
    check("drain_first_ch3", DW'(first3), DW'(6));
    drain_check("drain_drain");
    check("drain_word_count", DW'(n_wr), DW'(7));

    // Reset mid-burst, then ch0 must win over ch3.
    do_reset();
    autofill[1] = 1'b1;
    drive();
    repeat (6) step();
    #3;
    ip_rst_n = 1'b0;
    #1;
    check("midrst_rd", DW'(ch_read), '0);
    check("midrst_wr", DW'(out_write), '0);
    check("midrst_din", out_din, '0);
    check("midrst_chan", DW'(out_chan), '0);
    clear_model();
    @(posedge ip_clk);
    #1;
    ip_rst_n = 1'b1;
    q[0].push_back(mk(0, 100));
    q[3].push_back(mk(3, 100));
    drive();
    step();
    check("postrst_c0_rd", DW'(s_rd), '0);
    check("postrst_c0_wr", DW'(s_wr), '0);
    step();
    check("postrst_c1_rd", DW'(s_rd), DW'(4'b0001));
    check("postrst_c1_wr", DW'(s_wr), '0);
    step();
    check("postrst_c2_wr", DW'(s_wr), DW'(1));
    check("postrst_c2_din", s_din, mk(0, 100));
    drain_check("postrst_drain");

    // Random arrivals and back-pressure against the ordering scoreboard.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NC; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          q[i].push_back(mk(i, seqn[i]));
          seqn[i]++;
        end
      end
      out_full = ($urandom_range(0, 3) == 0);
      drive();
      step();
    end
    drain_check("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
